// File: rtl/cpc_ram512k_banker.sv
// CPC 512K RAM expansion banker: decodes the gate-array port write and maps
// Z80 16K pages onto a 512K SRAM, disabling host RAM on expansion hits.
module cpc_ram512k_banker #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RESET_B,
    input  logic       A15,
    input  logic       A14,
    input  logic [7:0] D,
    input  logic       MREQ_B,
    input  logic       IOREQ_B,
    input  logic       RD_B,
    input  logic       WR_B,
    input  logic       M1_B,
    input  logic       RFSH_B,
    input  logic       RAMRD_B,
    input  logic       dip0,
    input  logic       dip1,
    output logic [4:0] HIADR,
    output logic       RAMCS_B,
    output logic       RAMOE_B,
    output logic       RAMWE_B,
    output logic       RAMDIS
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        WAIT_REL = 2'd2
    } port_state_e;

    localparam logic [1:0] LAST_CNT = 2'(STROBE_CYCLES - 1);

    port_state_e state, state_next;
    logic [1:0]  cnt, cnt_next;
    logic        commit;
    logic        io_seen;
    logic [2:0]  cfg;
    logic [2:0]  bank;
    logic [1:0]  page;
    logic [1:0]  blk;
    logic        sel_hit;
    logic        hit;
    logic        port_det;
    logic        mem;
    logic        rd_hit;
    logic        wr_hit;
    logic        we_flag;
    logic        we_clr_n;
    logic [4:0]  hiadr_hold;

    // RAMRD_B already qualifies reads, so the raw RD_B strobe carries no extra information.
    logic unused;
    assign unused = RD_B;

    assign page     = {A15, A14};
    assign port_det = !IOREQ_B && !WR_B && M1_B && !A15 && A14 && (D[7:6] == 2'b11);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (port_det && io_seen) begin
                    if (STROBE_CYCLES == 1) begin
                        commit     = 1'b1;
                        state_next = WAIT_REL;
                    end else begin
                        cnt_next   = 2'd1;
                        state_next = ARM;
                    end
                end
            end
            ARM: begin
                if (!port_det) begin
                    cnt_next   = 2'd0;
                    state_next = IDLE;
                end else if (cnt == LAST_CNT) begin
                    commit     = 1'b1;
                    cnt_next   = 2'd0;
                    state_next = WAIT_REL;
                end else begin
                    cnt_next = cnt + 2'd1;
                end
            end
            WAIT_REL: begin
                if (IOREQ_B) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_hit = 1'b0;
        blk     = page;
        case (cfg)
            3'd1, 3'd3: begin
                sel_hit = (page == 2'd3);
                blk     = 2'd3;
            end
            3'd2: sel_hit = 1'b1;
            3'd4, 3'd5, 3'd6, 3'd7: begin
                sel_hit = (page == 2'd1);
                blk     = cfg[1:0];
            end
            default: sel_hit = 1'b0;
        endcase
    end

    assign hit    = sel_hit && dip0 && !(dip1 && (bank == 3'd0));
    assign mem    = !MREQ_B && RFSH_B;
    assign rd_hit = mem && hit && !RAMRD_B;
    assign wr_hit = mem && hit && !WR_B;

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            io_seen    <= 1'b0;
            cfg        <= 3'd0;
            bank       <= 3'd0;
            hiadr_hold <= 5'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (IOREQ_B) io_seen <= 1'b1;
            if (commit) begin
                cfg  <= D[2:0];
                bank <= D[5:3];
            end
            // NOTE: the held address is a clocked register, not a latch on !hit.
            if (hit) hiadr_hold <= {bank, blk};
        end
    end

    // NOTE: the write flag clears asynchronously as soon as WR_B or MREQ_B rises.
    assign we_clr_n = RESET_B && !WR_B && !MREQ_B;

    always_ff @(posedge CLK or negedge we_clr_n) begin
        if (!we_clr_n) we_flag <= 1'b0;
        else if (wr_hit) we_flag <= 1'b1;
    end

    assign HIADR   = hit ? {bank, blk} : hiadr_hold;
    assign RAMCS_B = !(rd_hit || wr_hit);
    assign RAMOE_B = !rd_hit;
    assign RAMWE_B = !(we_flag && wr_hit);
    assign RAMDIS  = rd_hit || wr_hit;

endmodule

// File: tb/tb_cpc_ram512k_banker.sv
// Self-checking bench for cpc_ram512k_banker: directed literal checks plus
// randomized bus traffic compared every cycle against a behavioural model.
module tb_cpc_ram512k_banker;

    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       RESET_B;
    logic       A15, A14;
    logic [7:0] D;
    logic       MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B, RAMRD_B;
    logic       dip0, dip1;
    logic [4:0] HIADR;
    logic       RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [2:0] m_cfg     = 3'd0;
    logic [2:0] m_bank    = 3'd0;
    int         m_run     = 0;
    bit         m_done    = 1'b0;
    bit         m_blocked = 1'b1;
    bit         m_flag    = 1'b0;
    logic [4:0] m_last    = 5'd0;

    cpc_ram512k_banker #(.STROBE_CYCLES(S)) dut (
        .CLK     (CLK),
        .RESET_B (RESET_B),
        .A15     (A15),
        .A14     (A14),
        .D       (D),
        .MREQ_B  (MREQ_B),
        .IOREQ_B (IOREQ_B),
        .RD_B    (RD_B),
        .WR_B    (WR_B),
        .M1_B    (M1_B),
        .RFSH_B  (RFSH_B),
        .RAMRD_B (RAMRD_B),
        .dip0    (dip0),
        .dip1    (dip1),
        .HIADR   (HIADR),
        .RAMCS_B (RAMCS_B),
        .RAMOE_B (RAMOE_B),
        .RAMWE_B (RAMWE_B),
        .RAMDIS  (RAMDIS)
    );

    always #5 CLK = ~CLK;

    function automatic logic [2:0] decode(input logic [2:0] cfg, input logic [1:0] p);
        if (cfg == 3'd1 && p == 2'd3) return {1'b1, 2'd3};
        if (cfg == 3'd2)              return {1'b1, p};
        if (cfg == 3'd3 && p == 2'd3) return {1'b1, 2'd3};
        if (cfg >= 3'd4 && p == 2'd1) return {1'b1, cfg[1:0]};
        return 3'b000;
    endfunction

    function automatic void model_map(output logic hit, output logic [1:0] blk);
        logic [2:0] d;
        d   = decode(m_cfg, {A15, A14});
        hit = d[2] && dip0 && !(dip1 && m_bank == 3'd0);
        blk = d[1:0];
    endfunction

    function automatic void model_reset();
        m_cfg     = 3'd0;
        m_bank    = 3'd0;
        m_run     = 0;
        m_done    = 1'b0;
        m_blocked = 1'b1;
        m_flag    = 1'b0;
        m_last    = 5'd0;
    endfunction

    // Model step on every rising edge, using the inputs the DUT samples there.
    initial forever begin
        logic       hit;
        logic [1:0] blk;
        bit         mem, det;
        @(posedge CLK);
        if (!RESET_B) begin
            model_reset();
        end else begin
            model_map(hit, blk);
            mem = !MREQ_B && RFSH_B;
            if (hit) m_last = {m_bank, blk};
            if (WR_B || MREQ_B) m_flag = 1'b0;
            else if (mem && hit) m_flag = 1'b1;
            det = !IOREQ_B && !WR_B && M1_B && !A15 && A14 && D[7:6] == 2'b11;
            if (IOREQ_B) begin
                m_run = 0; m_done = 1'b0; m_blocked = 1'b0;
            end else if (!det) begin
                m_run = 0;
            end else if (!m_done && !m_blocked) begin
                m_run++;
                if (m_run == S) begin
                    m_cfg  = D[2:0];
                    m_bank = D[5:3];
                    m_done = 1'b1;
                    m_run  = 0;
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    initial forever begin
        logic       hit;
        logic [1:0] blk;
        bit         mem, rd, wr;
        logic [4:0] e_hi;
        logic       e_cs, e_oe, e_we, e_dis;
        @(negedge CLK);
        if (!RESET_B) model_reset();
        if (WR_B || MREQ_B) m_flag = 1'b0;
        model_map(hit, blk);
        mem   = !MREQ_B && RFSH_B;
        rd    = mem && hit && !RAMRD_B;
        wr    = mem && hit && !WR_B;
        e_hi  = hit ? {m_bank, blk} : m_last;
        e_cs  = !(rd || wr);
        e_oe  = !rd;
        e_we  = !(m_flag && wr);
        e_dis = rd || wr;
        n_cmp++;
        if ({HIADR, RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS} !== {e_hi, e_cs, e_oe, e_we, e_dis}) begin
            n_bad++;
            $display("FAIL cycle_compare t=%0t: got hiadr=%b cs=%b oe=%b we=%b dis=%b, want hiadr=%b cs=%b oe=%b we=%b dis=%b",
                     $time, HIADR, RAMCS_B, RAMOE_B, RAMWE_B, RAMDIS, e_hi, e_cs, e_oe, e_we, e_dis);
        end
    end

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic idle_bus();
        MREQ_B = 1'b1; IOREQ_B = 1'b1; RD_B = 1'b1; WR_B = 1'b1;
        M1_B = 1'b1; RFSH_B = 1'b1; RAMRD_B = 1'b1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic bus_end();
        idle_bus();
        tick();
    endtask

    task automatic io_write(input logic [7:0] d, input int n);
        A15 = 1'b0; A14 = 1'b1; D = d;
        IOREQ_B = 1'b0; WR_B = 1'b0; M1_B = 1'b1;
        repeat (n) tick();
        bus_end();
    endtask

    task automatic mem_read(input logic a15, input logic a14);
        A15 = a15; A14 = a14;
        MREQ_B = 1'b0; RD_B = 1'b0; RAMRD_B = 1'b0;
    endtask

    initial begin
        RESET_B = 1'b0;
        idle_bus();
        D = 8'h00; dip0 = 1'b1; dip1 = 1'b0;
        mem_read(1'b1, 1'b1);
        @(negedge CLK);
        check("reset_hiadr", HIADR, 5'b00000);
        check("reset_cs", 5'(RAMCS_B), 5'd1);
        check("reset_oe", 5'(RAMOE_B), 5'd1);
        check("reset_we", 5'(RAMWE_B), 5'd1);
        check("reset_dis", 5'(RAMDIS), 5'd0);
        @(posedge CLK); #2;
        RESET_B = 1'b1;
        bus_end();

        // cfg=2 bank=0, read at &C000
        io_write(8'hC2, 3);
        mem_read(1'b1, 1'b1);
        @(negedge CLK);
        check("c2_read_hiadr", HIADR, 5'b00011);
        check("c2_read_cs", 5'(RAMCS_B), 5'd0);
        check("c2_read_oe", 5'(RAMOE_B), 5'd0);
        check("c2_read_dis", 5'(RAMDIS), 5'd1);
        bus_end();

        // bank=3 cfg=4, write at &4000 with one-cycle WE setup
        io_write(8'hDC, 2);
        A15 = 1'b0; A14 = 1'b1; MREQ_B = 1'b0; WR_B = 1'b0;
        @(negedge CLK);
        check("dc_write_hiadr", HIADR, 5'b01100);
        check("dc_write_cs", 5'(RAMCS_B), 5'd0);
        check("dc_we_setup", 5'(RAMWE_B), 5'd1);
        tick(); @(negedge CLK);
        check("dc_we_active1", 5'(RAMWE_B), 5'd0);
        tick(); @(negedge CLK);
        check("dc_we_active2", 5'(RAMWE_B), 5'd0);
        @(posedge CLK); #2;
        WR_B = 1'b1; #1;
        check("dc_we_release", 5'(RAMWE_B), 5'd1);
        bus_end();

        // 6128 mode: bank 0 stays internal, bank 1 maps
        dip1 = 1'b1;
        io_write(8'hC1, 2);
        mem_read(1'b1, 1'b1);
        @(negedge CLK);
        check("b0_6128_cs", 5'(RAMCS_B), 5'd1);
        check("b0_6128_dis", 5'(RAMDIS), 5'd0);
        bus_end();
        io_write(8'hC9, 2);
        mem_read(1'b1, 1'b1);
        @(negedge CLK);
        check("b1_6128_hiadr", HIADR, 5'b00111);
        check("b1_6128_cs", 5'(RAMCS_B), 5'd0);
        bus_end();

        // One-sample strobe and interrupt acknowledge never commit
        io_write(8'hC2, 1);
        mem_read(1'b0, 1'b1);
        @(negedge CLK);
        check("short_strobe_cs", 5'(RAMCS_B), 5'd1);
        bus_end();
        A15 = 1'b0; A14 = 1'b1; D = 8'hFF;
        IOREQ_B = 1'b0; M1_B = 1'b0; WR_B = 1'b0;
        repeat (3) tick();
        bus_end();
        mem_read(1'b0, 1'b1);
        @(negedge CLK);
        check("intack_cs", 5'(RAMCS_B), 5'd1);
        bus_end();
        mem_read(1'b1, 1'b1);
        @(negedge CLK);
        check("intack_keep_hiadr", HIADR, 5'b00111);
        bus_end();

        // Refresh in cfg=2 keeps strobes inactive
        dip1 = 1'b0;
        io_write(8'hC2, 2);
        A15 = 1'b1; A14 = 1'b1; MREQ_B = 1'b0; RFSH_B = 1'b0; RAMRD_B = 1'b0;
        @(negedge CLK);
        check("rfsh_cs", 5'(RAMCS_B), 5'd1);
        check("rfsh_oe", 5'(RAMOE_B), 5'd1);
        check("rfsh_we", 5'(RAMWE_B), 5'd1);
        check("rfsh_dis", 5'(RAMDIS), 5'd0);
        bus_end();

        // Reset mid memory write
        A15 = 1'b1; A14 = 1'b1; MREQ_B = 1'b0; WR_B = 1'b0;
        tick(); @(negedge CLK);
        check("prerst_we", 5'(RAMWE_B), 5'd0);
        @(posedge CLK); #2;
        RESET_B = 1'b0; #1;
        check("rst_async_cs", 5'(RAMCS_B), 5'd1);
        check("rst_async_we", 5'(RAMWE_B), 5'd1);
        check("rst_async_dis", 5'(RAMDIS), 5'd0);
        check("rst_async_hiadr", HIADR, 5'b00000);
        tick();
        RESET_B = 1'b1;
        tick(); @(negedge CLK);
        check("postrst_cs", 5'(RAMCS_B), 5'd1);
        bus_end();

        // Reset mid port write discards it; no arming until IOREQ_B rises
        io_write(8'hC2, 2);
        A15 = 1'b0; A14 = 1'b1; D = 8'hC2; IOREQ_B = 1'b0; WR_B = 1'b0;
        RESET_B = 1'b0;
        tick();
        RESET_B = 1'b1;
        repeat (3) tick();
        bus_end();
        mem_read(1'b1, 1'b1);
        @(negedge CLK);
        check("rst_port_nocommit_cs", 5'(RAMCS_B), 5'd1);
        bus_end();
        io_write(8'hC2, 2);
        mem_read(1'b1, 1'b1);
        @(negedge CLK);
        check("rearm_hiadr", HIADR, 5'b00011);
        check("rearm_cs", 5'(RAMCS_B), 5'd0);
        bus_end();

        // Randomized bus traffic, checked by the compare process
        for (int t = 0; t < 3000; t++) begin
            int kind, len;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 4);
            A15  = 1'($urandom);
            A14  = 1'($urandom);
            D    = 8'($urandom);
            if ($urandom_range(0, 1) == 0) D[7:6] = 2'b11;
            if ($urandom_range(0, 49) == 0) dip0 = 1'($urandom);
            if ($urandom_range(0, 29) == 0) dip1 = 1'($urandom);
            idle_bus();
            case (kind)
                0, 1: begin
                    MREQ_B = 1'b0; RD_B = 1'b0;
                    RAMRD_B = ($urandom_range(0, 3) == 0);
                end
                2, 3: begin
                    MREQ_B = 1'b0; WR_B = 1'b0;
                end
                4, 5: begin
                    if ($urandom_range(0, 3) != 0) begin A15 = 1'b0; A14 = 1'b1; end
                    IOREQ_B = 1'b0; WR_B = 1'b0;
                end
                6: begin
                    IOREQ_B = 1'b0; M1_B = 1'b0; WR_B = 1'($urandom);
                end
                7: begin
                    MREQ_B = 1'b0; RFSH_B = 1'b0; RAMRD_B = 1'($urandom);
                end
                9: begin
                    if ($urandom_range(0, 19) == 0) RESET_B = 1'b0;
                end
                default: ;
            endcase
            repeat (len) tick();
            RESET_B = 1'b1;
            if ($urandom_range(0, 2) != 0) bus_end();
        end
        bus_end();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpc_ram512k_banker.md
CPC_RAM512K_BANKER -- requirements
Module: cpc_ram512k_banker

Interface
REQ-001 Parameter STROBE_CYCLES, default 2: number of consecutive CLK samples with the I/O write asserted before the write is accepted (range 1-3).
REQ-002 CLK  in  1  Z80 bus clock (4 MHz); all state updates on its rising edge.
REQ-003 RESET_B  in  1  asynchronous, active-low reset.
REQ-004 A15, A14  in  1 each  upper address bits; select the 16K page and decode the gate-array port.
REQ-005 D  in  8  Z80 data bus; the block only reads it.
REQ-006 MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B  in  1 each  Z80 bus strobes, active-low.
REQ-007 RAMRD_B  in  1  active-low host RAM-read qualifier; ROM overlay is already removed from it.
REQ-008 dip0  in  1  1 = expansion enabled.
REQ-009 dip1  in  1  1 = 6128 mode; bank 0 is left to internal RAM.
REQ-010 HIADR  out  5  SRAM A18..A14 = {bank[2:0], blk[1:0]}.
REQ-011 RAMCS_B, RAMOE_B, RAMWE_B  out  1 each  SRAM strobes, active-low.
REQ-012 RAMDIS  out  1  active-high; disables host internal RAM.

Function
REQ-013 Port write detection: IOREQ_B=0, WR_B=0, M1_B=1, A15=0, A14=1, D[7:6]=11.
REQ-014 Port-write FSM states are IDLE, ARM, WAIT_REL.
REQ-015 IDLE -> ARM on the first CLK sample where the detect condition is true.
REQ-016 ARM counts consecutive true samples and commits on sample STROBE_CYCLES.
- Commit loads cfg <= D[2:0] and bank <= D[5:3] on that same edge.
- The FSM then moves to WAIT_REL.
REQ-017 ARM returns to IDLE without committing if the detect condition drops before the count completes.
REQ-018 WAIT_REL -> IDLE once IOREQ_B=1 is sampled, so each I/O cycle commits at most once.
REQ-019 Interrupt acknowledge (IOREQ_B=0 with M1_B=0) never arms the FSM.
REQ-020 Block select from page p = {A15,A14}, producing hit and blk:
- cfg=1, p=3 -> hit, blk=3.
- cfg=2 -> hit for any p, blk=p.
- cfg=3, p=3 -> hit, blk=3.
- cfg=4..7, p=1 -> hit, blk=cfg[1:0].
- all other cases -> no hit.
REQ-021 hit is forced to 0 when dip0=0, or when dip1=1 and bank=0.
REQ-022 Memory access condition: mem = MREQ_B=0 and RFSH_B=1.
REQ-023 Read hit: mem, hit and RAMRD_B=0.
- RAMCS_B=0, RAMOE_B=0 and RAMDIS=1, combinationally.
REQ-024 Write hit: mem, hit and WR_B=0.
- RAMCS_B=0 and RAMDIS=1, combinationally.
REQ-025 RAMWE_B is driven by a registered flag.
- Flag sets on the first CLK edge sampling a write hit, so the address has one cycle of setup.
- RAMWE_B is low only while the flag is set and WR_B=0.
- The flag clears asynchronously when WR_B or MREQ_B goes high.
REQ-026 HIADR = {bank, blk} whenever hit=1; it holds its last value otherwise and never glitches during a hit.
REQ-027 A port write during an expansion memory access changes the mapping only after commit; the current cycle keeps its mapping.
REQ-028 Refresh cycles (RFSH_B=0) never assert RAMCS_B, RAMWE_B or RAMDIS.
REQ-029 Outputs are inactive whenever hit=0: RAMCS_B=1, RAMOE_B=1, RAMWE_B=1, RAMDIS=0.

Reset
REQ-030 RESET_B=0 immediately forces the following, regardless of bus activity:
- cfg=0, bank=0, FSM=IDLE, write flag=0.
- HIADR=00000, RAMCS_B=1, RAMOE_B=1, RAMWE_B=1, RAMDIS=0.
REQ-031 Reset asserted mid-port-write discards that write; after release the FSM waits for IOREQ_B=1 before it can arm again.

Verification
REQ-032 Port &7Fxx write D=&C2 for 3 CLK -> cfg=2, bank=0 after edge 2; MREQ read at &C000 with dip1=0 -> HIADR=00011, RAMCS_B=0, RAMDIS=1.
REQ-033 Write D=&DC (bank=3, cfg=4), then memory write at &4000 -> HIADR=01100; RAMWE_B stays 1 for the first sampled cycle, then 0 until WR_B rises.
REQ-034 dip1=1, D=&C1 (bank 0) -> read at &C000 gives RAMCS_B=1, RAMDIS=0; then D=&C9 (bank 1) -> HIADR=00111.
REQ-035 I/O write lasting 1 CLK with STROBE_CYCLES=2 -> no commit; interrupt-acknowledge cycle with D=&FF -> no commit.
REQ-036 Refresh cycle with RFSH_B=0 in cfg=2 -> all SRAM strobes inactive.
REQ-037 RESET_B pulsed low mid-write after cfg=2 -> outputs inactive at once; cfg=0 after release; no expansion access until the next port write.
